sercmd_master: RTL and testbench

SERCMD_MASTER -- requirements
Module: sercmd_master

---
 rtl/sercmd_master.sv | 182 ++++++++++++++++++
 tb/tb_sercmd_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sercmd_master.sv
// ----------------------------------------------------------------------------
// sercmd_master
// Packet master for a byte-serial command link. Each accepted request goes
// out as cmd, addr, len, then either len payload bytes (write) or a wait for
// len received bytes (read), finishing with a one-cycle done pulse.
//
// Optional feature macro: SERCMD_TIMEOUT_EN
//   Defined   : an inter-byte watchdog runs in RDATA; on expiry err pulses
//               and the block returns to IDLE without done.
//   Undefined : RDATA waits indefinitely and err is tied low.
// ----------------------------------------------------------------------------
module sercmd_master #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        LEN,
        WDATA,
        RDATA,
        FIN
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    state_t     state;
    state_t     state_next;

    logic       write_q;
    logic [7:0] addr_q;
    logic [7:0] len_q;
    logic [7:0] remain_q;

    logic       accept;
    logic       wr_xfer;
    logic       rx_take;
    logic       timeout_fire;

    assign accept  = (state == IDLE) && req_valid;
    assign wr_xfer = (state == WDATA) && wr_valid && tx_ready;
    assign rx_take = (state == RDATA) && rx_strobe;

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic and per-state drive of the tx/wr/handshake outputs.
    always_comb begin
        // NOTE: defaults first; any path that skips an assignment would infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        wr_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = CMD;
            end
            CMD: begin
                tx_valid = 1'b1;
                tx_data  = write_q ? CMD_WRITE : CMD_READ;
                if (tx_ready) state_next = ADDR;
            end
            ADDR: begin
                tx_valid = 1'b1;
                tx_data  = addr_q;
                if (tx_ready) state_next = LEN;
            end
            LEN: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (tx_ready) begin
                    if (len_q == 8'd0)  state_next = FIN;
                    else if (write_q)   state_next = WDATA;
                    else                state_next = RDATA;
                end
            end
            WDATA: begin
                // Payload passes straight through; the upstream source owns stability.
                wr_ready = tx_ready;
                tx_valid = wr_valid;
                tx_data  = wr_data;
                if (wr_xfer && (remain_q == 8'd1)) state_next = FIN;
            end
            RDATA: begin
                // A byte in the expiry cycle wins over the timeout.
                if (rx_strobe && (remain_q == 8'd1)) state_next = FIN;
                else if (timeout_fire)               state_next = IDLE;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, remaining-byte counter and registered read-byte output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: only control and output flops exist here; each gets an explicit reset value.
            write_q  <= 1'b0;
            addr_q   <= 8'h00;
            len_q    <= 8'h00;
            remain_q <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                len_q    <= req_len;
                remain_q <= req_len;
            end
            if (wr_xfer) begin
                remain_q <= remain_q - 8'd1;
            end
            if (rx_take) begin
                rd_data  <= rx_data;
                rd_valid <= 1'b1;
                remain_q <= remain_q - 8'd1;
            end
        end
    end

`ifdef SERCMD_TIMEOUT_EN
    logic [23:0] to_cnt;
    logic        err_q;

    assign timeout_fire = (state == RDATA) && !rx_strobe &&
                          (to_cnt == (TIMEOUT_CYCLES - 24'd1));
    assign err          = err_q;

    // Inter-byte watchdog: held at zero outside RDATA, restarted by each byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= 24'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout_fire;
            if ((state != RDATA) || rx_strobe) to_cnt <= 24'd0;
            else                               to_cnt <= to_cnt + 24'd1;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_sercmd_master.sv
// ----------------------------------------------------------------------------
// tb_sercmd_master
// Directed bench for sercmd_master. A background agent logs tx transfers,
// read bytes and pulses, sources write payload and drives tx_ready; the main
// sequence issues requests and compares against hand-computed values.
// Honours SERCMD_TIMEOUT_EN for the timeout scenario.
// ----------------------------------------------------------------------------
module tb_sercmd_master;

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_q[$];
    int         done_cnt    = 0;
    int         err_cnt     = 0;
    int         stall_viol  = 0;
    logic       wr_ready_seen = 1'b0;
    logic       toggle_mode   = 1'b0;
    logic       tx_ready_set  = 1'b1;

    sercmd_master #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] packed_log();
        logic [63:0] v = 64'd0;
        foreach (tx_log[i]) v = {v[55:0], tx_log[i]};
        return v;
    endfunction

    function automatic logic [63:0] packed_rd();
        logic [63:0] v = 64'd0;
        foreach (rd_log[i]) v = {v[55:0], rd_log[i]};
        return v;
    endfunction

    // Agent: sample at negedge, update driven inputs at posedge+2.
    initial begin : agent
        logic       wx;
        logic       stall_prev;
        logic [7:0] data_prev;
        stall_prev = 1'b0;
        data_prev  = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                stall_prev = 1'b0;
                wx         = 1'b0;
            end else begin
                if (stall_prev && (!tx_valid || tx_data !== data_prev)) stall_viol++;
                stall_prev = tx_valid && !tx_ready;
                data_prev  = tx_data;
                if (tx_valid && tx_ready) tx_log.push_back(tx_data);
                if (rd_valid) rd_log.push_back(rd_data);
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (wr_ready) wr_ready_seen = 1'b1;
                wx = wr_valid && wr_ready;
            end
            @(posedge clock);
            #2;
            if (wx && wr_q.size() != 0) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() != 0);
            wr_data  = wr_valid ? wr_q[0] : 8'h00;
            tx_ready = toggle_mode ? ~tx_ready : tx_ready_set;
        end
    end

    task automatic start_req(input logic w, input logic [7:0] a, input logic [7:0] l);
        int n = 0;
        @(posedge clock);
        #1;
        while (!req_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_tx(input int cnt, input string tag);
        int n = 0;
        while (tx_log.size() < cnt && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, 64'(tx_log.size()), 64'(cnt));
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_strobe = 1'b1;
        rx_data   = b;
        @(posedge clock);
        #1;
        rx_strobe = 1'b0;
    endtask

    initial begin : main
        int d0;
        int e0;
        int n;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_len   = 8'h00;
        wr_data   = 8'h00;
        wr_valid  = 1'b0;
        tx_ready  = 1'b1;
        rx_data   = 8'h00;
        rx_strobe = 1'b0;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_rd_data", {56'd0, rd_data}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("post_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
        check("post_rst_done", {63'd0, done}, 64'd0);
        check("post_rst_err", {63'd0, err}, 64'd0);

        // Write addr 04 len 2 payload a7 b7
        tx_log.delete();
        wr_q.push_back(8'ha7);
        wr_q.push_back(8'hb7);
        start_req(1'b1, 8'h04, 8'd2);
        wait_done(1, "wr_done");
        check("wr_tx_count", 64'(tx_log.size()), 64'd5);
        check("wr_tx_bytes", packed_log(), 64'h02_04_02_a7_b7);
        @(negedge clock);
        check("wr_done_single", 64'(done_cnt), 64'd1);
        check("wr_no_err", 64'(err_cnt), 64'd0);

        // Read addr 01 len 2, after a stray rx byte in IDLE
        tx_log.delete();
        rd_log.delete();
        rx_pulse(8'hee);
        start_req(1'b0, 8'h01, 8'd2);
        wait_tx(3, "rd_tx_count");
        check("rd_tx_bytes", packed_log(), 64'h01_01_02);
        repeat (2) @(posedge clock);
        rx_pulse(8'h3c);
        @(negedge clock);
        check("rd_valid_1", {63'd0, rd_valid}, 64'd1);
        check("rd_data_1", {56'd0, rd_data}, 64'h3c);
        @(negedge clock);
        check("rd_valid_pulse", {63'd0, rd_valid}, 64'd0);
        repeat (3) @(posedge clock);
        rx_pulse(8'h5d);
        wait_done(2, "rd_done");
        check("rd_bytes", packed_rd(), 64'h3c_5d);
        check("rd_count", 64'(rd_log.size()), 64'd2);

        // Write len 3 with tx_ready toggling every cycle
        tx_log.delete();
        stall_viol = 0;
        wr_q.push_back(8'h11);
        wr_q.push_back(8'h22);
        wr_q.push_back(8'h33);
        toggle_mode = 1'b1;
        start_req(1'b1, 8'h20, 8'd3);
        wait_done(3, "tog_done");
        toggle_mode  = 1'b0;
        tx_ready_set = 1'b1;
        check("tog_tx_count", 64'(tx_log.size()), 64'd6);
        check("tog_tx_bytes", packed_log(), 64'h02_20_03_11_22_33);
        check("tog_stall_stable", 64'(stall_viol), 64'd0);

        // Zero-length write
        repeat (2) @(posedge clock);
        tx_log.delete();
        wr_ready_seen = 1'b0;
        start_req(1'b1, 8'haa, 8'd0);
        wait_done(4, "len0_done");
        check("len0_tx_bytes", packed_log(), 64'h02_aa_00);
        check("len0_tx_count", 64'(tx_log.size()), 64'd3);
        check("len0_wr_ready", {63'd0, wr_ready_seen}, 64'd0);

        // Read len 2 with only one byte delivered
        tx_log.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(1'b0, 8'h33, 8'd2);
        wait_tx(3, "to_tx_count");
        @(posedge clock);
        #1;
        rx_strobe = 1'b1;
        rx_data   = 8'h77;
        @(posedge clock);
        #1;
        rx_strobe = 1'b0;
        n = 0;
`ifdef SERCMD_TIMEOUT_EN
        while (n < 40) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (err) break;
        end
        check("to_err_delay", 64'(n), 64'd16);
        @(negedge clock);
        check("to_err_pulse", {63'd0, err}, 64'd0);
        check("to_err_count", 64'(err_cnt - e0), 64'd1);
        check("to_no_done", 64'(done_cnt - d0), 64'd0);
        check("to_req_ready", {63'd0, req_ready}, 64'd1);
`else
        repeat (40) @(negedge clock);
        check("noto_no_err", 64'(err_cnt - e0), 64'd0);
        check("noto_no_done", 64'(done_cnt - d0), 64'd0);
        check("noto_stuck", {63'd0, req_ready}, 64'd0);
`endif
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("to_recover_ready", {63'd0, req_ready}, 64'd1);

        // Reset while stalled in ADDR, then a normal write
        tx_log.delete();
        tx_ready_set = 1'b0;
        repeat (2) @(posedge clock);
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(1'b1, 8'h10, 8'd1);
        tx_ready_set = 1'b1;
        @(posedge clock);
        #1;
        tx_ready_set = 1'b0;
        @(negedge clock);
        check("addr_stall_valid", {63'd0, tx_valid}, 64'd1);
        check("addr_stall_data", {56'd0, tx_data}, 64'h10);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_addr_tx_valid", {63'd0, tx_valid}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n      = 1'b1;
        tx_ready_set = 1'b1;
        check("rst_addr_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_addr_no_err", 64'(err_cnt - e0), 64'd0);
        repeat (2) @(posedge clock);
        tx_log.delete();
        wr_q.push_back(8'h5e);
        start_req(1'b1, 8'h10, 8'd1);
        wait_done(d0 + 1, "post_rst_done_cnt");
        check("post_rst_tx_bytes", packed_log(), 64'h02_10_01_5e);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
